// File: rtl/tt_memop_seq.sv
// Frames one vector memop: accepts a descriptor, pulses sync_start, streams index regs, pulses sync_end.
// Latency: sync_start 1 cycle after accept; first VRF read 2 cycles after accept; index chunk 1 cycle after its read.
// Backpressure: o_req_ready is high only in IDLE; descriptors presented in any other state are ignored.
module tt_memop_seq #(
   parameter int VLEN         = 256,
   parameter int MAX_IDX_REGS = 8
) (
   input  logic                       i_clk,
   input  logic                       i_reset_n,
   input  logic                       i_req_valid,
   output logic                       o_req_ready,
   input  logic                       i_req_masked,
   input  logic                       i_req_indexed,
   input  logic [$clog2(VLEN+1)-1:0]  i_req_vl,
   input  logic [1:0]                 i_req_eew,
   input  logic [4:0]                 i_req_idx_vreg,
   input  logic [VLEN-1:0]            i_req_mask_data,
   output logic                       o_is_masked_memop,
   output logic                       o_is_indexed,
   output logic [$clog2(VLEN+1)-1:0]  o_vl,
   output logic [1:0]                 o_eew,
   output logic [VLEN-1:0]            o_mask_data,
   output logic                       o_memop_sync_start,
   output logic                       o_memop_sync_end,
   output logic                       o_vrf_rd_en,
   output logic [4:0]                 o_vrf_rd_addr,
   input  logic [VLEN-1:0]            i_vrf_rd_data,
   output logic [VLEN-1:0]            o_index_data,
   output logic                       o_index_data_valid,
   output logic                       o_last_index,
   input  logic                       i_mask_idx_valid,
   input  logic                       i_mask_idx_last_idx,
   input  logic                       i_lsu_done,
   output logic                       o_req_illegal
);

   localparam int VLW = $clog2(VLEN+1);
   localparam int NW  = VLW + 6;
   // VLEN is a power of two, so the ceiling divide reduces to add-and-shift.
   localparam int SH  = $clog2(VLEN);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_IDX,
      S_WAIT,
      S_END
   } state_t;

   state_t           r_state;
   logic             r_req_ready;
   logic             r_req_illegal;
   logic             r_sync_start;
   logic             r_sync_end;
   logic             r_masked;
   logic             r_indexed;
   logic [VLW-1:0]   r_vl;
   logic [1:0]       r_eew;
   logic [VLEN-1:0]  r_mask;
   logic [4:0]       r_idx_vreg;
   logic [NW-1:0]    r_n_regs;
   logic [NW-1:0]    r_rd_cnt;
   logic             r_rd_en;
   logic [4:0]       r_rd_addr;
   logic             r_last_rd;
   logic             r_lsu_seen;
   logic             r_last_seen;
   logic             r_idx_vld;
   logic             r_idx_last;

   logic [2:0]       w_shamt;
   logic [NW-1:0]    w_bits;
   logic [NW-1:0]    w_bits_rnd;
   logic [NW-1:0]    w_n_regs;
   logic             w_req_illegal;
   logic             w_need_fsm;
   logic             w_lsu_hit;
   logic             w_last_hit;
   logic             w_done;
   logic             w_active;

   // Index group size in registers: ceil(vl * 8<<eew / VLEN).
   assign w_shamt       = {1'b0, i_req_eew} + 3'd3;
   assign w_bits        = {6'b0, i_req_vl} << w_shamt;
   assign w_bits_rnd    = w_bits + NW'(VLEN - 1);
   assign w_n_regs      = w_bits_rnd >> SH;
   assign w_req_illegal = i_req_indexed && (w_n_regs > NW'(MAX_IDX_REGS));

   // An indexed op with vl=0 streams nothing, so the mask/index FSM never issues a last item;
   // a masked-only op still runs the FSM and must see its last item even when vl=0.
   assign w_need_fsm = r_indexed ? (r_vl != '0) : r_masked;
   assign w_lsu_hit  = r_lsu_seen | i_lsu_done;
   assign w_last_hit = r_last_seen | (i_mask_idx_valid & i_mask_idx_last_idx);
   assign w_done     = w_lsu_hit && (w_last_hit || !w_need_fsm);
   assign w_active   = (r_state == S_START) || (r_state == S_IDX) || (r_state == S_WAIT);

   // Main sequencer: descriptor accept, framing pulses, index read issue and completion tracking.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state       <= S_IDLE;
         r_req_ready   <= 1'b1;
         r_req_illegal <= 1'b0;
         r_sync_start  <= 1'b0;
         r_sync_end    <= 1'b0;
         r_masked      <= 1'b0;
         r_indexed     <= 1'b0;
         r_vl          <= '0;
         r_eew         <= '0;
         r_mask        <= '0;
         r_idx_vreg    <= '0;
         r_n_regs      <= '0;
         r_rd_cnt      <= '0;
         r_rd_en       <= 1'b0;
         r_rd_addr     <= '0;
         r_last_rd     <= 1'b0;
         r_lsu_seen    <= 1'b0;
         r_last_seen   <= 1'b0;
      end else begin
         r_req_illegal <= 1'b0;
         r_sync_start  <= 1'b0;
         r_sync_end    <= 1'b0;

         if (w_active) begin
            if (i_lsu_done) begin
               r_lsu_seen <= 1'b1;
            end
            if (i_mask_idx_valid && i_mask_idx_last_idx) begin
               r_last_seen <= 1'b1;
            end
         end

         case (r_state)
            S_IDLE: begin
               if (i_req_valid) begin
                  if (w_req_illegal) begin
                     r_req_illegal <= 1'b1;
                  end else begin
                     r_masked     <= i_req_masked;
                     r_indexed    <= i_req_indexed;
                     r_vl         <= i_req_vl;
                     r_eew        <= i_req_eew;
                     r_mask       <= i_req_mask_data;
                     r_idx_vreg   <= i_req_idx_vreg;
                     r_n_regs     <= i_req_indexed ? w_n_regs : '0;
                     r_lsu_seen   <= 1'b0;
                     r_last_seen  <= 1'b0;
                     r_req_ready  <= 1'b0;
                     r_sync_start <= 1'b1;
                     r_state      <= S_START;
                  end
               end
            end
            S_START: begin
               if (r_n_regs != '0) begin
                  r_rd_en   <= 1'b1;
                  r_rd_addr <= r_idx_vreg;
                  r_rd_cnt  <= NW'(1);
                  r_last_rd <= (r_n_regs == NW'(1));
                  r_state   <= S_IDX;
               end else begin
                  r_state   <= S_WAIT;
               end
            end
            S_IDX: begin
               // r_rd_cnt counts reads already on the port, including this cycle's.
               if (r_rd_cnt == r_n_regs) begin
                  r_rd_en   <= 1'b0;
                  r_last_rd <= 1'b0;
                  r_state   <= S_WAIT;
               end else begin
                  r_rd_en   <= 1'b1;
                  r_rd_addr <= r_rd_addr + 5'd1;
                  r_rd_cnt  <= r_rd_cnt + NW'(1);
                  r_last_rd <= ((r_rd_cnt + NW'(1)) == r_n_regs);
               end
            end
            S_WAIT: begin
               if (w_done) begin
                  r_sync_end <= 1'b1;
                  r_state    <= S_END;
               end
            end
            S_END: begin
               r_masked    <= 1'b0;
               r_indexed   <= 1'b0;
               r_vl        <= '0;
               r_eew       <= '0;
               r_mask      <= '0;
               r_req_ready <= 1'b1;
               r_state     <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   // VRF return tracking: data arrives one cycle after each read, so delay the read strobe and last tag.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_idx_vld  <= 1'b0;
         r_idx_last <= 1'b0;
      end else begin
         r_idx_vld  <= r_rd_en;
         r_idx_last <= r_rd_en & r_last_rd;
      end
   end

   assign o_req_ready        = r_req_ready;
   assign o_req_illegal      = r_req_illegal;
   assign o_memop_sync_start = r_sync_start;
   assign o_memop_sync_end   = r_sync_end;
   assign o_is_masked_memop  = r_masked;
   assign o_is_indexed       = r_indexed;
   assign o_vl               = r_vl;
   assign o_eew              = r_eew;
   assign o_mask_data        = r_mask;
   assign o_vrf_rd_en        = r_rd_en;
   assign o_vrf_rd_addr      = r_rd_addr;
   assign o_index_data       = i_vrf_rd_data;
   assign o_index_data_valid = r_idx_vld;
   assign o_last_index       = r_idx_last;

endmodule
